// File: rtl/bit8div_seq.sv
// bit8div_seq: sequential restoring divider, {dividend_h,dividend_l} / divisor.
// Produces a WIDTH-bit quotient and remainder after WIDTH shift/subtract steps.
// The flag bits are {rem==0, quot==0, overflow, div-by-zero}.
// Optional build macro DIV_SIGNED_EN: the operands are two's complement. The
// datapath divides magnitudes, and the signs are fixed up when the result is loaded.
// Without the macro, the block is purely unsigned and has no sign logic.
//
// Handshake: start is sampled only while the FSM is IDLE. The operands are
// latched on that edge, and later input changes are ignored. A start seen in
// any other state is dropped, not queued. busy is high in CHECK and RUN. done
// is high for exactly one cycle (DONE). quot/rem/flag are valid from that
// cycle and are held afterwards. The next start may arrive in the cycle right
// after done.
module bit8div_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_h,
  input  logic [WIDTH-1:0] dividend_l,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic [3:0]       flag,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched operands. In signed builds these hold magnitudes.
  logic [WIDTH-1:0] dvd_h_reg;
  logic [WIDTH-1:0] dvd_l_reg;
  logic [WIDTH-1:0] dvs_reg;

  // Partial remainder (one guard bit), quotient shift register, step count.
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    step;

  // Single restoring step.
  logic [WIDTH:0]   r_sh;
  logic             r_ge;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  // Early-out conditions and the result that is loaded on entry to DONE.
  logic             err_div0;
  logic             err_ovf;
  logic             last_step;
  logic [WIDTH-1:0] res_quot;
  logic [WIDTH-1:0] res_rem;
  logic             res_div0;
  logic             res_ovf;

  // Operand values to latch on start.
  logic [WIDTH-1:0] ld_h;
  logic [WIDTH-1:0] ld_l;
  logic [WIDTH-1:0] ld_d;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  logic [2*WIDTH-1:0] dvd_full;
  logic [2*WIDTH-1:0] dvd_abs;
  logic               neg_q;
  logic               neg_r;

  // Magnitudes of the two's complement operands.
  always_comb begin
    dvd_full = {dividend_h, dividend_l};
    dvd_abs  = dvd_full[2*WIDTH-1] ? -dvd_full : dvd_full;
    ld_h     = dvd_abs[2*WIDTH-1:WIDTH];
    ld_l     = dvd_abs[WIDTH-1:0];
    ld_d     = divisor[WIDTH-1] ? -divisor : divisor;
  end
`else
  // Unsigned build: the operands are latched as-is.
  always_comb begin
    ld_h = dividend_h;
    ld_l = dividend_l;
    ld_d = divisor;
  end
`endif

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (err_div0 || err_ovf) ? S_DONE : S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs, decoded from the state.
  always_comb begin
    busy      = (state == S_CHECK) || (state == S_RUN);
    done      = (state == S_DONE);
    dbg_state = state;
  end

  // One shift/compare/subtract step and the early-out checks.
  always_comb begin
    r_sh      = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    r_ge      = (r_sh >= {1'b0, dvs_reg});
    r_step    = r_ge ? (r_sh - {1'b0, dvs_reg}) : r_sh;
    q_step    = {q_reg[WIDTH-2:0], r_ge};
    err_div0  = (dvs_reg == '0);
    err_ovf   = (dvd_h_reg >= dvs_reg);
    last_step = (step == LAST_STEP);
  end

  // Result selection: an early-out error from CHECK, or the final RUN step.
  always_comb begin
    res_quot = q_step;
    res_rem  = r_step[WIDTH-1:0];
    res_div0 = 1'b0;
    res_ovf  = 1'b0;
    if (state == S_CHECK) begin
      res_quot = '1;
      res_rem  = '0;
      // Divide-by-zero wins over overflow; only one of the two is reported.
      if (err_div0) res_div0 = 1'b1;
      else          res_ovf  = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      // Apply the signs. A negative quotient may reach -2^(WIDTH-1).
      // A positive quotient must stay below 2^(WIDTH-1).
      if (neg_q) begin
        res_ovf  = (q_step > HALF);
        res_quot = -q_step;
      end else begin
        res_ovf  = q_step[WIDTH-1];
      end
      if (neg_r) res_rem = -r_step[WIDTH-1:0];
      if (res_ovf) begin
        res_quot = '1;
        res_rem  = '0;
      end
`endif
    end
  end

  // Datapath: latch on start, iterate in RUN, load the result on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_h_reg <= '0;
      dvd_l_reg <= '0;
      dvs_reg   <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      step      <= '0;
      quot      <= '0;
      rem       <= '0;
      flag      <= 4'b1100;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd_h_reg <= ld_h;
            dvd_l_reg <= ld_l;
            dvs_reg   <= ld_d;
            flag[1:0] <= 2'b00;
`ifdef DIV_SIGNED_EN
            neg_q     <= dividend_h[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r     <= dividend_h[WIDTH-1];
`endif
          end
        end
        S_CHECK: begin
          r_reg <= {1'b0, dvd_h_reg};
          q_reg <= dvd_l_reg;
          step  <= '0;
          if (err_div0 || err_ovf) begin
            quot <= res_quot;
            rem  <= res_rem;
            flag <= {(res_rem == '0), (res_quot == '0), res_ovf, res_div0};
          end
        end
        S_RUN: begin
          r_reg <= r_step;
          q_reg <= q_step;
          step  <= step + CW'(1);
          if (last_step) begin
            quot <= res_quot;
            rem  <= res_rem;
            flag <= {(res_rem == '0), (res_quot == '0), res_ovf, res_div0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
